bf16_accum: RTL
===============

// Module: bf16_accum
// PURPOSE
//  Multi-cycle bfloat16 (1/8/7) accumulator. Sits directly downstream of the int->bf16 converter.
//  Adds each accepted bf16 operand into an internal running sum: acc <= acc + in.
//  Exposes the sum plus sticky overflow/NaN status to the FPU result path.
//  Interface: valid/ready in, done pulse out. No denormals, matching the converter's output range.
// PARAMETERS
//  GUARD_BITS  3  extra LSBs below the 7-bit fraction: guard, round, sticky
//  SAT_ON_OVF  0  0: overflow -> signed inf; 1: overflow -> signed max finite (0x7F7F/0xFF7F)
// PORTS
//  clk_i       in   1   clock, rising edge
//  rst_i       in   1   reset, asynchronous, active-high
//  clear_i     in   1   sync clear of accumulator and flags; aborts any operation in flight
//  in_valid_i  in   1   operand valid
//  in_ready_o  out  1   operand accepted when in_valid_i & in_ready_o
//  in_data_i   in   16  bf16 operand
//  acc_o       out  16  registered accumulator value (bf16)
//  done_o      out  1   one-cycle pulse: acc_o has just been updated
//  ovf_o       out  1   sticky: an overflow occurred since reset/clear
//  nan_o       out  1   sticky: accumulator holds NaN
// BEHAVIOUR
//  Reset: state=IDLE; acc_o=0x0000; done_o=0; ovf_o=0; nan_o=0. in_ready_o=1 after reset deasserts.
//  FSM: IDLE -> ALIGN -> ADD -> NORM -> IDLE.
//   - in_ready_o = (state==IDLE) & ~clear_i, combinational.
//   - Accept in IDLE at cycle N; ALIGN at N+1, ADD at N+2, NORM at N+3.
//   - At N+4: acc_o updated, done_o=1, state=IDLE, so in_ready_o=1 again.
//   - Fixed latency 4; throughput one operand per 4 cycles.
//  Operand decode: exp==0 -> zero (fraction ignored). exp==255 & frac==0 -> inf. exp==255 & frac!=0 -> NaN.
//  ALIGN: pick larger-magnitude operand (compare exp, then mantissa).
//   - Smaller mantissa = {1,frac,GUARD_BITS zeros}, shifted right by exp diff.
//   - Shifted-out bits OR into the sticky bit.
//   - diff >= 8+GUARD_BITS: smaller operand reduces to sticky only.
//  ADD: same signs -> add magnitudes; different signs -> larger minus smaller. Result takes the larger operand's sign.
//  NORM:
//   - Carry out -> shift right 1, keep sticky, exp+1.
//   - Otherwise shift left by leading-zero count, exp-=lzc.
//   - Round to nearest even on G/R/S; rounding carry may bump exp.
//   - Exact zero -> +0x0000 (also for x + -x).
//   - Biased exp >= 255 -> overflow: result per SAT_ON_OVF, ovf_o<=1.
//   - Biased exp <= 0 -> flush to signed zero; no flag.
//  Specials, resolved in ALIGN; ADD/NORM pass through:
//   - Any NaN operand, or inf + -inf -> 0x7FC0, nan_o<=1.
//   - Otherwise any inf -> that inf.
//   - NaN stays sticky in acc until clear.
//  clear_i (any state): next edge acc_o=0x0000, ovf_o=0, nan_o=0, state=IDLE, done_o=0.
//   - The in-flight result is discarded. clear_i beats a simultaneous in_valid_i; the operand is not accepted.
//  rst_i mid-operation: immediate return to reset values; no done_o.
//  in_data_i is sampled only on accept; changes after accept are ignored.
// STRUCTURE
//  fpu_pkg (shared):
//   - typedef bf16_t packed struct {sign, exp[7:0], frac[6:0]}.
//   - Constants BF16_EXP_W=8, BF16_FRAC_W=7, BF16_BIAS=127.
//   - BF16_QNAN=16'h7FC0, BF16_PINF=16'h7F80, BF16_NINF=16'hFF80, BF16_MAXF=16'h7F7F.
//   - Enum accum_state_e {IDLE, ALIGN, ADD, NORM}.
//  Sub-module bf16_lzc: parameterised-width leading-zero counter, combinational, used in NORM.
//  Pipeline registers between states hold: sign, exp, extended mantissas, special flags.
// TESTING
//  1 Reset: assert rst_i async mid-cycle -> acc_o=0x0000, done_o=0, ovf_o=0, nan_o=0, in_ready_o=1 after release.
//  2 Sum: accept 0x3F80 (1.0), then 0x4000 (2.0) -> acc_o=0x3F80, then 0x4040; done_o exactly 4 cycles after each accept; in_ready_o low in between.
//  3 Cancel/round: 0x4040 + 0xC040 -> 0x0000; then 0x3F80 + 0x3B80 (half-ulp tie) -> 0x3F80 (tie to even).
//  4 Overflow: 0x7F7F + 0x7F7F -> 0x7F80, ovf_o=1; with SAT_ON_OVF=1 -> 0x7F7F, ovf_o=1.
//  5 Specials: 0x7F80 then 0xFF80 -> 0x7FC0, nan_o=1; then 0x3F80 -> acc stays 0x7FC0.
//  6 Clear: accept 0x3F80, assert clear_i in the ALIGN cycle -> no done_o, acc_o=0x0000; clear_i with in_valid_i in IDLE -> not accepted.

Source files
------------

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared bfloat16 definitions for the FPU blocks: field layout, format
// constants, special encodings, the accumulator state enum and small
// classification helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int BF16_EXP_W  = 8;
    localparam int BF16_FRAC_W = 7;
    localparam int BF16_BIAS   = 127;

    localparam logic [15:0] BF16_QNAN  = 16'h7FC0;
    localparam logic [15:0] BF16_PINF  = 16'h7F80;
    localparam logic [15:0] BF16_NINF  = 16'hFF80;
    localparam logic [15:0] BF16_MAXF  = 16'h7F7F;
    localparam logic [15:0] BF16_NMAXF = 16'hFF7F;

    typedef struct packed {
        logic                   sign;
        logic [BF16_EXP_W-1:0]  exp;
        logic [BF16_FRAC_W-1:0] frac;
    } bf16_t;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM
    } accum_state_e;

    function automatic logic is_nan(input bf16_t v);
        return (v.exp == 8'hFF) && (v.frac != '0);
    endfunction

    function automatic logic is_inf(input bf16_t v);
        return (v.exp == 8'hFF) && (v.frac == '0);
    endfunction

endpackage

// File: rtl/bf16_accum_lzc.sv
// -----------------------------------------------------------------------------
// bf16_lzc
// Combinational leading-zero counter used to renormalise the accumulator sum.
// Ports:
//   value  in   W    word to scan from the MSB down
//   count  out  CW   number of leading zeros (W when value is all zero)
// -----------------------------------------------------------------------------
module bf16_lzc #(
    parameter int W  = 11,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Scan LSB to MSB so the highest set bit is the last one to write count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bf16_accum.sv
// -----------------------------------------------------------------------------
// bf16_accum
// Multi-cycle bfloat16 accumulator: acc <= acc + operand, one operand every
// four cycles (IDLE -> ALIGN -> ADD -> NORM), round to nearest even, no
// denormals, sticky overflow and NaN status.
// Ports:
//   clk_i       in   1   clock, rising edge
//   rst_i       in   1   asynchronous active-high reset
//   clear_i     in   1   synchronous clear of accumulator/flags, aborts work
//   in_valid_i  in   1   operand valid
//   in_ready_o  out  1   high in IDLE when no clear is requested
//   in_data_i   in   16  bf16 operand, sampled on accept only
//   acc_o       out  16  registered accumulator value
//   done_o      out  1   one-cycle pulse when acc_o has just been updated
//   ovf_o       out  1   sticky overflow since reset/clear
//   nan_o       out  1   sticky: accumulator holds NaN
// -----------------------------------------------------------------------------
module bf16_accum
    import fpu_pkg::*;
#(
    parameter int GUARD_BITS = 3,
    parameter bit SAT_ON_OVF = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in_data_i,
    output logic [15:0] acc_o,
    output logic        done_o,
    output logic        ovf_o,
    output logic        nan_o
);

    // Extended mantissa: hidden one, fraction, guard/round/sticky bits.
    localparam int MW  = 1 + BF16_FRAC_W + GUARD_BITS;
    localparam int LZW = $clog2(MW + 1);

    accum_state_e state_q, state_next;

    logic [15:0]   acc_q, op_q, spec_val_q;
    logic          done_q, ovf_q, nan_q;
    logic [MW-1:0] big_mant_q, small_mant_q;
    logic [7:0]    exp_q;
    logic          sign_q, sub_q, spec_q, spec_nan_q;
    logic [MW:0]   sum_q;

    bf16_t         acc_f, op_f;
    logic [MW-1:0] mant_a, mant_b, big_mant, small_mant, shifted, aligned;
    logic [7:0]    big_exp, small_exp, diff;
    logic          a_is_big, big_sign, small_sign, lost;
    logic          a_nan, b_nan, a_inf, b_inf, spec, spec_nan;
    logic [15:0]   spec_val;

    logic [LZW-1:0]    lz;
    logic [MW-1:0]     norm;
    logic signed [9:0] exp_n, exp_r;
    logic              guard_b, rest_b, lsb_b, round_up, norm_ovf;
    logic [8:0]        rnd;
    logic [6:0]        frac_r;
    logic [15:0]       norm_result;

    assign acc_f      = acc_q;
    assign op_f       = op_q;
    assign in_ready_o = (state_q == IDLE) & ~clear_i;
    assign acc_o      = acc_q;
    assign done_o     = done_q;
    assign ovf_o      = ovf_q;
    assign nan_o      = nan_q;

    // State register; reset and clear both land in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Fixed four-step walk once an operand is taken; clear wins from any state.
    always_comb begin
        state_next = state_q;
        if (clear_i) begin
            state_next = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid_i) state_next = ALIGN;
                ALIGN:   state_next = ADD;
                ADD:     state_next = NORM;
                NORM:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Alignment: order the two operands by magnitude, shift the smaller one
    // right and fold every bit that falls off into the sticky LSB. Zeros get
    // a zero mantissa so they never contribute a hidden one. Specials are
    // resolved here and simply carried through the later stages.
    always_comb begin
        mant_a     = (acc_f.exp == '0) ? '0 : {1'b1, acc_f.frac, {GUARD_BITS{1'b0}}};
        mant_b     = (op_f.exp == '0)  ? '0 : {1'b1, op_f.frac, {GUARD_BITS{1'b0}}};
        a_is_big   = (acc_f.exp > op_f.exp) || ((acc_f.exp == op_f.exp) && (mant_a >= mant_b));
        big_exp    = a_is_big ? acc_f.exp  : op_f.exp;
        small_exp  = a_is_big ? op_f.exp   : acc_f.exp;
        big_mant   = a_is_big ? mant_a     : mant_b;
        small_mant = a_is_big ? mant_b     : mant_a;
        big_sign   = a_is_big ? acc_f.sign : op_f.sign;
        small_sign = a_is_big ? op_f.sign  : acc_f.sign;
        diff       = big_exp - small_exp;
        if (diff >= 8'(MW)) begin
            shifted = '0;
            lost    = |small_mant;
        end else begin
            shifted = small_mant >> diff;
            lost    = |(small_mant & ((MW'(1) << diff) - MW'(1)));
        end
        aligned  = shifted | MW'(lost);

        a_nan    = is_nan(acc_f);
        b_nan    = is_nan(op_f);
        a_inf    = is_inf(acc_f);
        b_inf    = is_inf(op_f);
        spec     = a_nan | b_nan | a_inf | b_inf;
        spec_nan = a_nan | b_nan | (a_inf & b_inf & (acc_f.sign ^ op_f.sign));
        spec_val = spec_nan ? BF16_QNAN : (a_inf ? acc_q : op_q);
    end

    bf16_lzc #(
        .W (MW),
        .CW(LZW)
    ) u_lzc (
        .value(sum_q[MW-1:0]),
        .count(lz)
    );

    // Normalisation and rounding: a carry shifts right by one (keeping the
    // sticky), otherwise shift the leading one up to the MSB. Round to nearest
    // even needs GUARD_BITS >= 2 so that guard and the rest are distinct.
    // The exponent is kept signed and wide so both overflow and underflow
    // are visible before it is packed back into 8 bits.
    always_comb begin
        if (sum_q[MW]) begin
            norm    = sum_q[MW:1];
            norm[0] = sum_q[1] | sum_q[0];
            exp_n   = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            norm  = sum_q[MW-1:0] << lz;
            exp_n = $signed({2'b00, exp_q}) - $signed({{(10-LZW){1'b0}}, lz});
        end
        guard_b  = norm[GUARD_BITS-1];
        rest_b   = |norm[GUARD_BITS-2:0];
        lsb_b    = norm[GUARD_BITS];
        round_up = guard_b & (rest_b | lsb_b);
        rnd      = {1'b0, norm[MW-1:GUARD_BITS]} + 9'(round_up);
        if (rnd[8]) begin
            exp_r  = exp_n + 10'sd1;
            frac_r = '0;
        end else begin
            exp_r  = exp_n;
            frac_r = rnd[6:0];
        end

        norm_ovf = 1'b0;
        if (spec_q) begin
            norm_result = spec_val_q;
        end else if (sum_q == '0) begin
            norm_result = 16'h0000;
        end else if (exp_r >= 10'sd255) begin
            norm_ovf = 1'b1;
            if (SAT_ON_OVF) begin
                norm_result = sign_q ? BF16_NMAXF : BF16_MAXF;
            end else begin
                norm_result = sign_q ? BF16_NINF : BF16_PINF;
            end
        end else if (exp_r <= 10'sd0) begin
            norm_result = {sign_q, 15'h0000};
        end else begin
            norm_result = {sign_q, exp_r[7:0], frac_r};
        end
    end

    // Datapath registers between the stages plus the architectural state.
    // A clear drops whatever is in flight because the FSM returns to IDLE
    // and the accumulator is never written by the abandoned operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q        <= '0;
            op_q         <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            nan_q        <= 1'b0;
            big_mant_q   <= '0;
            small_mant_q <= '0;
            exp_q        <= '0;
            sign_q       <= 1'b0;
            sub_q        <= 1'b0;
            spec_q       <= 1'b0;
            spec_nan_q   <= 1'b0;
            spec_val_q   <= '0;
            sum_q        <= '0;
        end else if (clear_i) begin
            acc_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            nan_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid_i) op_q <= in_data_i;
                end
                ALIGN: begin
                    big_mant_q   <= big_mant;
                    small_mant_q <= aligned;
                    exp_q        <= big_exp;
                    sign_q       <= big_sign;
                    sub_q        <= big_sign ^ small_sign;
                    spec_q       <= spec;
                    spec_nan_q   <= spec_nan;
                    spec_val_q   <= spec_val;
                end
                ADD: begin
                    sum_q <= sub_q ? ({1'b0, big_mant_q} - {1'b0, small_mant_q})
                                   : ({1'b0, big_mant_q} + {1'b0, small_mant_q});
                end
                NORM: begin
                    acc_q  <= norm_result;
                    done_q <= 1'b1;
                    if (norm_ovf) ovf_q <= 1'b1;
                    if (spec_q & spec_nan_q) nan_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
